// File: rtl/algo_2r1w_ma_arb_if.sv
// Bundle between the requesters/control side and the write arbiter.
// The master drives requests and control; the slave (arbiter) returns backpressure and the core write port.
interface algo_2r1w_ma_arb_if #(
    parameter int NUMMAPT = 4,
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13
);
    logic                       ready;
    logic [NUMMAPT-1:0]         ma_write;
    logic [NUMMAPT*BITADDR-1:0] ma_adr;
    logic [NUMMAPT*WIDTH-1:0]   ma_din;
    logic [7:0]                 bp_thr;
    logic                       wr_stall;
    logic [NUMMAPT-1:0]         ma_bp;
    logic                       write;
    logic [BITADDR-1:0]         wr_adr;
    logic [WIDTH-1:0]           din;
    logic [NUMMAPT-1:0]         ovf_err;
    logic                       idle;

    modport master (
        output ready, ma_write, ma_adr, ma_din, bp_thr, wr_stall,
        input  ma_bp, write, wr_adr, din, ovf_err, idle
    );

    modport slave (
        input  ready, ma_write, ma_adr, ma_din, bp_thr, wr_stall,
        output ma_bp, write, wr_adr, din, ovf_err, idle
    );
endinterface

// File: rtl/algo_2r1w_ma_arb.sv
// Posted-write collector: one FIFO per requester, round-robin drained into a single core write port.
// Pushes are always accepted while space exists; draining waits for ready and a free write port.
module algo_2r1w_ma_arb #(
    parameter int NUMMAPT = 4,
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int FIFODEP = 16,
    parameter int BITFIFO = 4
) (
    input  logic              clk,
    input  logic              rst,
    algo_2r1w_ma_arb_if.slave bus
);
    localparam int              GW       = (NUMMAPT > 1) ? $clog2(NUMMAPT) : 1;
    localparam logic [BITFIFO:0] FULL    = (BITFIFO+1)'(FIFODEP);
    localparam logic [GW-1:0]   LAST_RST = GW'(NUMMAPT - 1);

    logic [BITADDR-1:0] adr_mem_q [NUMMAPT][FIFODEP];
    logic [WIDTH-1:0]   dat_mem_q [NUMMAPT][FIFODEP];
    logic [BITFIFO-1:0] wptr_q    [NUMMAPT];
    logic [BITFIFO-1:0] rptr_q    [NUMMAPT];
    logic [BITFIFO:0]   cnt_q     [NUMMAPT];
    logic [BITFIFO:0]   cnt_d     [NUMMAPT];
    logic [NUMMAPT-1:0] ovf_q, ovf_d;
    logic [NUMMAPT-1:0] push_ok, pop_hit, bp;
    logic [GW-1:0]      last_gnt_q, pop_sel;
    logic               pop_vld, drain_en, all_empty;
    logic               write_q;
    logic [BITADDR-1:0] wr_adr_q;
    logic [WIDTH-1:0]   din_q;

    assign drain_en = bus.ready & ~bus.wr_stall;

    // Round-robin search over FIFOs that were non-empty before this cycle's pushes.
    always_comb begin : arb
        int idx;
        idx     = 0;
        pop_vld = 1'b0;
        pop_sel = last_gnt_q;
        for (int k = 1; k <= NUMMAPT; k++) begin
            idx = (int'(last_gnt_q) + k) % NUMMAPT;
            if (drain_en && !pop_vld && (cnt_q[idx] != '0)) begin
                pop_vld = 1'b1;
                pop_sel = GW'(idx);
            end
        end
    end

    // A full FIFO still accepts a push when it is popped in the same cycle.
    always_comb begin : occ
        all_empty = 1'b1;
        pop_hit   = '0;
        push_ok   = '0;
        ovf_d     = ovf_q;
        bp        = '0;
        for (int i = 0; i < NUMMAPT; i++) begin
            pop_hit[i] = pop_vld && (pop_sel == GW'(i));
            push_ok[i] = bus.ma_write[i] && ((cnt_q[i] != FULL) || pop_hit[i]);
            ovf_d[i]   = ovf_q[i] | (bus.ma_write[i] & ~push_ok[i]);
            cnt_d[i]   = cnt_q[i] + (BITFIFO+1)'(push_ok[i]) - (BITFIFO+1)'(pop_hit[i]);
            bp[i]      = (8'(cnt_q[i]) >= bus.bp_thr);
            if (cnt_q[i] != '0) all_empty = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUMMAPT; i++) begin
                cnt_q[i]  <= '0;
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
            ovf_q      <= '0;
            last_gnt_q <= LAST_RST;
            write_q    <= 1'b0;
            wr_adr_q   <= '0;
            din_q      <= '0;
        end else begin
            for (int i = 0; i < NUMMAPT; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (push_ok[i]) wptr_q[i] <= wptr_q[i] + BITFIFO'(1);
                if (pop_hit[i]) rptr_q[i] <= rptr_q[i] + BITFIFO'(1);
            end
            ovf_q   <= ovf_d;
            write_q <= pop_vld;
            // Output stage: popped entry is registered onto the core write port.
            if (pop_vld) begin
                last_gnt_q <= pop_sel;
                wr_adr_q   <= adr_mem_q[pop_sel][rptr_q[pop_sel]];
                din_q      <= dat_mem_q[pop_sel][rptr_q[pop_sel]];
            end
        end
    end

    // Storage needs no reset: pointers and counts define which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUMMAPT; i++) begin
            if (push_ok[i]) begin
                adr_mem_q[i][wptr_q[i]] <= bus.ma_adr[i*BITADDR +: BITADDR];
                dat_mem_q[i][wptr_q[i]] <= bus.ma_din[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.ma_bp   = bp;
    assign bus.write   = write_q;
    assign bus.wr_adr  = wr_adr_q;
    assign bus.din     = din_q;
    assign bus.ovf_err = ovf_q;
    assign bus.idle    = all_empty & ~write_q;
endmodule
